// File: rtl/if_stage_controller.sv
// if_stage_controller: fetch sequencing for the PC and IF/ID, ID/EX flush.
// Arbitrates EXE branch, memory wait and hazard stall; replays a redirect held back while memory was busy.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hazard            ID-stage data hazard (hold PC and IF/ID)
//   exe_branch_taken  EXE branch resolved taken this cycle
//   exe_branch_addr   EXE branch target
//   mem_ready         instruction memory delivers a word this cycle
//   freeze            hold PC
//   Branch_Tacken     load Branch_Address into PC this cycle
//   Branch_Address    branch target to PC mux
//   flush             clear IF/ID and ID/EX
//   if_valid          IF/ID captures a valid instruction
//   state             BOOT=0, RUN=1, REDIRECT=2
//   stall_count       saturating count of frozen cycles outside BOOT
module if_stage_controller #(
    parameter int BOOT_CYCLES = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard,
    input  logic                   exe_branch_taken,
    input  logic [31:0]            exe_branch_addr,
    input  logic                   mem_ready,
    output logic                   freeze,
    output logic                   Branch_Tacken,
    output logic [31:0]            Branch_Address,
    output logic                   flush,
    output logic                   if_valid,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int BOOT_N = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
    localparam int BOOT_W = (BOOT_N > 1) ? $clog2(BOOT_N) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_N - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_RUN      = 2'd1,
        S_REDIRECT = 2'd2,
        S_BAD      = 2'd3
    } state_t;

    state_t            cur;
    state_t            nxt;
    logic [BOOT_W-1:0] boot_cnt;
    logic [31:0]       pending_addr;
    logic              load_pending;

    // One-hot decode of the RUN priority chain:
    // branch > memory wait > hazard > normal fetch.
    logic br_now;
    logic br_buf;
    logic mem_wait;
    logic hz_stall;
    logic fetch;

    assign br_now   = exe_branch_taken & mem_ready;
    assign br_buf   = exe_branch_taken & ~mem_ready;
    assign mem_wait = ~exe_branch_taken & ~mem_ready;
    assign hz_stall = ~exe_branch_taken & mem_ready & hazard;
    assign fetch    = ~exe_branch_taken & mem_ready & ~hazard;

    assign state = cur;

    always_comb begin
        nxt            = cur;
        freeze         = 1'b0;
        flush          = 1'b0;
        Branch_Tacken  = 1'b0;
        if_valid       = 1'b0;
        Branch_Address = exe_branch_addr;
        load_pending   = 1'b0;
        unique case (cur)
            S_BOOT: begin
                freeze = 1'b1;
                flush  = 1'b1;
                if (boot_cnt == BOOT_LAST) nxt = S_RUN;
            end
            S_RUN: begin
                unique case (1'b1)
                    br_now: begin
                        Branch_Tacken = 1'b1;
                        flush         = 1'b1;
                    end
                    br_buf: begin
                        freeze       = 1'b1;
                        flush        = 1'b1;
                        load_pending = 1'b1;
                        nxt          = S_REDIRECT;
                    end
                    mem_wait: freeze   = 1'b1;
                    hz_stall: freeze   = 1'b1;
                    fetch:    if_valid = 1'b1;
                endcase
            end
            S_REDIRECT: begin
                // New branches/hazards here come from wrong-path instructions.
                flush          = 1'b1;
                Branch_Address = pending_addr;
                if (mem_ready) begin
                    Branch_Tacken = 1'b1;
                    nxt           = S_RUN;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: begin
                freeze = 1'b1;
                flush  = 1'b1;
                nxt    = S_BOOT;
            end
        endcase
        if (rst) begin
            freeze         = 1'b1;
            flush          = 1'b1;
            Branch_Tacken  = 1'b0;
            if_valid       = 1'b0;
            Branch_Address = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= S_BOOT;
            boot_cnt     <= '0;
            pending_addr <= '0;
            stall_count  <= '0;
        end else begin
            cur <= nxt;
            // Cleared outside BOOT so recovery from S_BAD gets a full hold.
            boot_cnt <= (cur == S_BOOT) ? boot_cnt + 1'b1 : '0;
            if (load_pending) pending_addr <= exe_branch_addr;
            if (cur != S_BOOT && freeze && stall_count != STALL_MAX)
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage_controller.sv
// tb_if_stage_controller: table vectors, hand sequences and random stimulus
// against a cycle-level reference model, on two parameterisations.
module tb_if_stage_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard;
    logic        exe_branch_taken;
    logic [31:0] exe_branch_addr;
    logic        mem_ready;

    logic        fz [2];
    logic        tk [2];
    logic        fl [2];
    logic        iv [2];
    logic [31:0] ba [2];
    logic [1:0]  st [2];
    logic [15:0] sc0;
    logic [3:0]  sc1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    if_stage_controller #(.BOOT_CYCLES(4), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .hazard(hazard),
        .exe_branch_taken(exe_branch_taken),
        .exe_branch_addr(exe_branch_addr), .mem_ready(mem_ready),
        .freeze(fz[0]), .Branch_Tacken(tk[0]), .Branch_Address(ba[0]),
        .flush(fl[0]), .if_valid(iv[0]), .state(st[0]),
        .stall_count(sc0)
    );

    if_stage_controller #(.BOOT_CYCLES(0), .STALL_CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .hazard(hazard),
        .exe_branch_taken(exe_branch_taken),
        .exe_branch_addr(exe_branch_addr), .mem_ready(mem_ready),
        .freeze(fz[1]), .Branch_Tacken(tk[1]), .Branch_Address(ba[1]),
        .flush(fl[1]), .if_valid(iv[1]), .state(st[1]),
        .stall_count(sc1)
    );

    // Reference model: remaining boot cycles, a buffered-redirect flag
    // with its address, and a saturating stall tally per instance.
    int          m_boot  [2];
    bit          m_redir [2];
    logic [31:0] m_pend  [2];
    int          m_stall [2];
    bit          m_valid = 1'b0;
    int          boot_len [2] = '{4, 1};
    int          stall_max [2] = '{65535, 15};

    logic        e_fz [2];
    logic        e_tk [2];
    logic        e_fl [2];
    logic        e_iv [2];
    logic [31:0] e_ba [2];
    logic [1:0]  e_st [2];

    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic int sc_of(input int k);
        return (k == 0) ? int'(sc0) : int'(sc1);
    endfunction

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            e_st[k] = (m_boot[k] > 0) ? 2'd0 : (m_redir[k] ? 2'd2 : 2'd1);
            e_fz[k] = 1'b0; e_tk[k] = 1'b0; e_fl[k] = 1'b0; e_iv[k] = 1'b0;
            e_ba[k] = exe_branch_addr;
            if (rst) begin
                e_fz[k] = 1'b1; e_fl[k] = 1'b1; e_ba[k] = 32'h0;
            end else if (e_st[k] == 2'd0) begin
                e_fz[k] = 1'b1; e_fl[k] = 1'b1;
            end else if (e_st[k] == 2'd2) begin
                e_fl[k] = 1'b1;
                e_ba[k] = m_pend[k];
                e_tk[k] = mem_ready;
                e_fz[k] = !mem_ready;
            end else if (exe_branch_taken) begin
                e_fl[k] = 1'b1;
                e_tk[k] = mem_ready;
                e_fz[k] = !mem_ready;
            end else if (!mem_ready || hazard) begin
                e_fz[k] = 1'b1;
            end else begin
                e_iv[k] = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_boot[k] = boot_len[k];
                m_redir[k] = 1'b0;
                m_pend[k] = 32'h0;
                m_stall[k] = 0;
            end else if (m_boot[k] > 0) begin
                m_boot[k]--;
            end else begin
                if (e_fz[k] && m_stall[k] < stall_max[k]) m_stall[k]++;
                if (m_redir[k]) begin
                    if (mem_ready) m_redir[k] = 1'b0;
                end else if (exe_branch_taken && !mem_ready) begin
                    m_redir[k] = 1'b1;
                    m_pend[k] = exe_branch_addr;
                end
            end
        end
        if (rst) m_valid = 1'b1;
    endtask

    task automatic apply(input logic r, input logic h, input logic b,
                         input logic [31:0] a, input logic m);
        rst = r; hazard = h; exe_branch_taken = b;
        exe_branch_addr = a; mem_ready = m;
        @(negedge clk);
        model_eval();
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d.state", k), st[k], e_st[k]);
                chk($sformatf("m%0d.freeze", k), fz[k], e_fz[k]);
                chk($sformatf("m%0d.tk", k), tk[k], e_tk[k]);
                chk($sformatf("m%0d.addr", k), ba[k], e_ba[k]);
                chk($sformatf("m%0d.flush", k), fl[k], e_fl[k]);
                chk($sformatf("m%0d.valid", k), iv[k], e_iv[k]);
                chk($sformatf("m%0d.stall", k), sc_of(k), m_stall[k]);
            end
        end
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, h, b;
        logic [31:0] a;
        logic        m;
        logic [1:0]  st;
        logic        fz, tk;
        logic [31:0] ea;
        logic        fl, v;
        int          sc;
    } vec_t;

    vec_t tab [20];

    initial begin
        //          r  h  b  addr        m   st fz tk ea          fl v  sc
        tab[0]  = '{1, 0, 0, 32'h0,      1,  0, 1, 0, 32'h0,      1, 0, 0};
        tab[1]  = '{1, 0, 0, 32'h0,      1,  0, 1, 0, 32'h0,      1, 0, 0};
        tab[2]  = '{0, 0, 0, 32'h0,      1,  0, 1, 0, 32'h0,      1, 0, 0};
        tab[3]  = '{0, 0, 0, 32'h0,      1,  0, 1, 0, 32'h0,      1, 0, 0};
        tab[4]  = '{0, 0, 0, 32'h0,      1,  0, 1, 0, 32'h0,      1, 0, 0};
        tab[5]  = '{0, 0, 0, 32'h0,      1,  0, 1, 0, 32'h0,      1, 0, 0};
        tab[6]  = '{0, 0, 0, 32'h0,      1,  1, 0, 0, 32'h0,      0, 1, 0};
        tab[7]  = '{0, 1, 0, 32'h0,      1,  1, 1, 0, 32'h0,      0, 0, 0};
        tab[8]  = '{0, 1, 0, 32'h0,      1,  1, 1, 0, 32'h0,      0, 0, 1};
        tab[9]  = '{0, 1, 0, 32'h0,      1,  1, 1, 0, 32'h0,      0, 0, 2};
        tab[10] = '{0, 0, 0, 32'h0,      1,  1, 0, 0, 32'h0,      0, 1, 3};
        tab[11] = '{0, 1, 1, 32'h40,     1,  1, 0, 1, 32'h40,     1, 0, 3};
        tab[12] = '{0, 0, 1, 32'h80,     0,  1, 1, 0, 32'h80,     1, 0, 3};
        tab[13] = '{0, 0, 0, 32'h0,      0,  2, 1, 0, 32'h80,     1, 0, 4};
        tab[14] = '{0, 0, 1, 32'hC0,     0,  2, 1, 0, 32'h80,     1, 0, 5};
        tab[15] = '{0, 0, 0, 32'h0,      1,  2, 0, 1, 32'h80,     1, 0, 6};
        tab[16] = '{0, 0, 0, 32'h0,      1,  1, 0, 0, 32'h0,      0, 1, 6};
        tab[17] = '{0, 0, 1, 32'h100,    0,  1, 1, 0, 32'h100,    1, 0, 6};
        tab[18] = '{1, 0, 0, 32'h0,      1,  2, 1, 0, 32'h0,      1, 0, 7};
        tab[19] = '{0, 0, 0, 32'h0,      1,  0, 1, 0, 32'h0,      1, 0, 0};

        apply(1, 0, 0, 32'h0, 1);
        advance();

        foreach (tab[i]) begin
            apply(tab[i].r, tab[i].h, tab[i].b, tab[i].a, tab[i].m);
            chk($sformatf("v%0d.state", i), st[0], tab[i].st);
            chk($sformatf("v%0d.freeze", i), fz[0], tab[i].fz);
            chk($sformatf("v%0d.tk", i), tk[0], tab[i].tk);
            chk($sformatf("v%0d.addr", i), ba[0], tab[i].ea);
            chk($sformatf("v%0d.flush", i), fl[0], tab[i].fl);
            chk($sformatf("v%0d.valid", i), iv[0], tab[i].v);
            chk($sformatf("v%0d.stall", i), sc0, tab[i].sc);
            advance();
        end

        // Fresh reset, boot lengths 4 vs 1, then 20 memory-wait cycles.
        apply(1, 0, 0, 32'h0, 1);
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 32'h0, 1);
            chk("boot4.state", st[0], 2'd0);
            chk("boot1.state", st[1], (i == 0) ? 2'd0 : 2'd1);
            advance();
        end
        repeat (20) begin
            apply(0, 0, 0, 32'h0, 0);
            advance();
        end
        apply(0, 0, 0, 32'h0, 1);
        chk("sat.w4", sc1, 4'd15);
        chk("sat.w16", sc0, 16'd20);
        advance();

        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom,
                  $urandom_range(0, 2) != 0);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage_controller.md
Name: if_stage_controller

Overview:
Sequencing controller for the instruction-fetch datapath. It generates the freeze, branch-select and branch-target controls that drive the PC, and a flush for the IF/ID and ID/EX registers. It arbitrates between four inputs: EXE-stage branch resolution, ID-stage hazard stalls, a multi-cycle instruction-memory ready signal, and a post-reset boot hold. It buffers a branch redirect that arrives while memory is busy and replays it once memory is ready.

Parameters:
BOOT_CYCLES, 4, cycles the PC is held after reset deasserts; 0 is treated as 1
STALL_CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
hazard  in  1  ID-stage data hazard; hold PC and IF/ID
exe_branch_taken  in  1  branch resolved taken in EXE this cycle
exe_branch_addr  in  32  target of the EXE branch
mem_ready  in  1  instruction memory returns a valid word this cycle
freeze  out  1  hold PC (to PC freeze input)
Branch_Tacken  out  1  load Branch_Address into PC this cycle
Branch_Address  out  32  branch target to PC mux
flush  out  1  clear IF/ID and ID/EX contents
if_valid  out  1  IF/ID captures a valid instruction this cycle
state  out  2  BOOT=0, RUN=1, REDIRECT=2 (3 unused; recover to BOOT)
stall_count  out  STALL_CNT_W  cycles with freeze=1 outside BOOT, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- While rst=1:
  - Outputs are forced to freeze=1, flush=1, Branch_Tacken=0, if_valid=0, Branch_Address=0.
  - At the clock edge: state<=BOOT, boot counter<=0, pending_addr<=0, stall_count<=0.
- Outputs are combinational from state, registers and inputs, so they take effect in the same cycle. Registers update on the clk rising edge.
- Input priority in RUN: exe_branch_taken > !mem_ready > hazard.
- BOOT state:
  - freeze=1, flush=1, Branch_Tacken=0, if_valid=0.
  - The counter increments each cycle. When counter==max(BOOT_CYCLES,1)-1, the next state is RUN.
  - hazard, mem_ready and exe_branch_taken are ignored.
- RUN, branch taken with memory ready (exe_branch_taken=1, mem_ready=1):
  - Branch_Tacken=1, Branch_Address=exe_branch_addr, freeze=0, flush=1, if_valid=0.
  - Stay in RUN.
- RUN, branch taken with memory busy (exe_branch_taken=1, mem_ready=0):
  - pending_addr<=exe_branch_addr.
  - freeze=1, flush=1, Branch_Tacken=0.
  - Next state REDIRECT.
- RUN, no branch, memory busy (mem_ready=0): freeze=1, flush=0, if_valid=0; stay in RUN.
- RUN, hazard only (hazard=1, mem_ready=1): freeze=1, flush=0, if_valid=0; stay in RUN.
- RUN, otherwise: freeze=0, Branch_Tacken=0, flush=0, if_valid=1.
- REDIRECT state:
  - flush=1 every cycle; exe_branch_taken and hazard are ignored (they belong to wrong-path instructions).
  - mem_ready=0: freeze=1, Branch_Tacken=0.
  - mem_ready=1: Branch_Tacken=1, Branch_Address=pending_addr, freeze=0; next state RUN.
- Branch_Address when Branch_Tacken=0: pending_addr in REDIRECT, exe_branch_addr otherwise (don't-care to the PC).
- stall_count:
  - Increments on every edge with rst=0, state!=BOOT and freeze=1.
  - Holds at 2^STALL_CNT_W-1 once reached.
- Reset mid-operation: a REDIRECT in progress is discarded and pending_addr is cleared. After reset the PC restarts from its own reset value.
- Latency: redirect with mem_ready=1 is 0 cycles (same-cycle Branch_Tacken). A buffered redirect is applied in the first cycle with mem_ready=1 after entering REDIRECT.

Test Plan:
- Boot: rst=1 for 2 cycles, then 0, with BOOT_CYCLES=4, mem_ready=1 -> freeze=1 and state=0 for exactly 4 cycles; then state=1, freeze=0, if_valid=1; stall_count=0.
- Hazard: in RUN, hazard=1 for 3 cycles -> freeze=1, flush=0, if_valid=0 for 3 cycles; stall_count=3; then if_valid=1.
- Immediate branch: exe_branch_taken=1, exe_branch_addr=0x40, mem_ready=1, hazard=1 -> same cycle Branch_Tacken=1, Branch_Address=0x40, flush=1, freeze=0; state stays 1.
- Buffered branch: exe_branch_taken=1, addr=0x80, mem_ready=0 for 3 cycles, then a second exe_branch_taken=1 with addr=0xC0 during REDIRECT -> state=2, flush=1 throughout. On the mem_ready=1 cycle, Branch_Tacken=1 with Branch_Address=0x80 (0xC0 ignored); then state=1.
- Reset in REDIRECT: enter REDIRECT with addr=0x100, assert rst for 1 cycle -> state=0, Branch_Tacken never asserted, pending_addr=0, stall_count=0.
- Saturation: STALL_CNT_W=4, mem_ready=0 for 20 RUN cycles -> stall_count reaches 15 and holds at 15.
